// File: rtl/di_pkg.sv
// Shared types for the DI scratch terminal: read FSM encoding and status codes.
package di_pkg;

  // Read-side FSM states
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_VALID = 2'd2
  } rd_state_e;

  // Values reported on di_transfer_status
  localparam logic [15:0] ST_OK       = 16'd0;
  localparam logic [15:0] ST_ODD_ADDR = 16'd1;
  localparam logic [15:0] ST_OVERRUN  = 16'd2;

  // A word may still move while fewer than len bytes have been transferred;
  // lengths are even, so this also guarantees room for the whole word.
  function automatic logic have_room(input logic [31:0] count, input logic [31:0] len);
    return count < len;
  endfunction

endpackage

// File: rtl/scratch_ram.sv
// Single-port synchronous RAM, one-cycle registered read (read-before-write).
module scratch_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is never reset, so contents survive a terminal reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/di_scratch_term.sv
// DI scratch-buffer terminal: word-addressed RAM behind the DI read/write handshake.
module di_scratch_term
  import di_pkg::*;
#(
  parameter logic [15:0] TERM_ADDR  = 16'h0040,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic [15:0] di_term_addr,
  input  logic [31:0] di_reg_addr,
  input  logic [31:0] di_len,
  input  logic        di_write_mode,
  input  logic        di_read_mode,
  input  logic        di_write,
  input  logic [15:0] di_reg_datai,
  input  logic        di_read_req,
  input  logic        di_read,
  output logic [15:0] di_reg_datao,
  output logic        di_read_rdy,
  output logic        di_write_rdy,
  output logic [15:0] di_transfer_status,
  output logic        di_en
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [31:0]           count_q, count_d;
  logic [15:0]           status_q, status_d;
  logic                  active_q, active_d;
  logic                  write_rdy_q, write_rdy_d;

  logic                  active, start;
  logic                  wr_path, rd_path;
  logic                  wr_strobe, rd_strobe;
  logic                  room, wr_do, rd_do, overrun;
  logic [15:0]           ram_rdata;
  logic [31-ADDR_WIDTH:0] unused_addr_hi;

  // Upper address bits simply alias onto the buffer
  assign unused_addr_hi = di_reg_addr[31:ADDR_WIDTH+1];

  assign di_en   = (di_term_addr == TERM_ADDR);
  assign active  = di_en & (di_write_mode | di_read_mode);
  assign start   = active & ~active_q;

  // Writes win when both modes are up; the read side then sits idle
  assign wr_path = di_en & di_write_mode;
  assign rd_path = di_en & di_read_mode & ~di_write_mode;

  assign wr_strobe = write_rdy_q & wr_path & di_write;
  assign rd_strobe = (state_q == RD_VALID) & rd_path & di_read;
  assign room      = have_room(count_q, di_len);
  assign wr_do     = wr_strobe & room;
  assign rd_do     = rd_strobe & room;
  assign overrun   = (wr_strobe | rd_strobe) & ~room;

  assign di_write_rdy       = write_rdy_q & wr_path;
  assign di_transfer_status = status_q;

  // Pointer, byte count, status and handshake bookkeeping
  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    status_d    = status_q;
    active_d    = active;
    write_rdy_d = wr_path;
    if (start) begin
      ptr_d    = di_reg_addr[ADDR_WIDTH:1];
      count_d  = '0;
      status_d = di_reg_addr[0] ? ST_ODD_ADDR : ST_OK;
    end else if (wr_do || rd_do) begin
      ptr_d   = ptr_q + PTR_ONE;
      count_d = count_q + 32'd2;
    end else if (overrun) begin
      status_d = ST_OVERRUN;
    end
  end

  // Bookkeeping registers; reset aborts any transaction in flight
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      ptr_q       <= '0;
      count_q     <= '0;
      status_q    <= ST_OK;
      active_q    <= 1'b0;
      write_rdy_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      status_q    <= status_d;
      active_q    <= active_d;
      write_rdy_q <= write_rdy_d;
    end
  end

  // Read FSM state register
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state: FETCH covers the single cycle of RAM latency
  always_comb begin
    state_d = state_q;
    if (!rd_path) begin
      state_d = RD_IDLE;
    end else begin
      unique case (state_q)
        RD_IDLE:  if (di_read_req) state_d = RD_FETCH;
        RD_FETCH: state_d = RD_VALID;
        RD_VALID: if (rd_do) state_d = RD_FETCH;
        default:  state_d = RD_IDLE;
      endcase
    end
  end

  // Read FSM outputs: data is only presented while a word is ready
  always_comb begin
    di_read_rdy  = (state_q == RD_VALID) & di_en;
    di_reg_datao = di_read_rdy ? ram_rdata : 16'd0;
  end

  scratch_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_W     (16)
  ) u_ram (
    .clk   (ifclk),
    .we    (wr_do),
    .addr  (ptr_q),
    .wdata (di_reg_datai),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_di_scratch_term.sv
// Directed bench for di_scratch_term: table of write/readback transactions plus
// hand sequences for read timing, read overrun, foreign terminal and reset.
module tb_di_scratch_term;

  localparam logic [15:0] TERM = 16'h0040;

  logic        ifclk = 1'b0;
  logic        resetb;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic [31:0] di_len;
  logic        di_write_mode, di_read_mode, di_write;
  logic [15:0] di_reg_datai;
  logic        di_read_req, di_read;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy, di_write_rdy;
  logic [15:0] di_transfer_status;
  logic        di_en;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [1024];
  logic [15:0] tdat  [258];
  logic [15:0] wrap_dat [4];

  typedef struct {
    logic [31:0] wa;
    logic [31:0] ra;
    logic [31:0] len;
    int          nw;
    logic [15:0] st;
  } vec_t;

  vec_t tbl [7];

  di_scratch_term #(.TERM_ADDR(TERM), .ADDR_WIDTH(10)) dut (
    .ifclk              (ifclk),
    .resetb             (resetb),
    .di_term_addr       (di_term_addr),
    .di_reg_addr        (di_reg_addr),
    .di_len             (di_len),
    .di_write_mode      (di_write_mode),
    .di_read_mode       (di_read_mode),
    .di_write           (di_write),
    .di_reg_datai       (di_reg_datai),
    .di_read_req        (di_read_req),
    .di_read            (di_read),
    .di_reg_datao       (di_reg_datao),
    .di_read_rdy        (di_read_rdy),
    .di_write_rdy       (di_write_rdy),
    .di_transfer_status (di_transfer_status),
    .di_en              (di_en)
  );

  always #5 ifclk = ~ifclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ifclk);
    #1;
  endtask

  task automatic start_txn(input bit wr, input logic [31:0] a, input logic [31:0] len);
    di_reg_addr   = a;
    di_len        = len;
    di_write_mode = wr;
    di_read_mode  = !wr;
    tick();
  endtask

  task automatic close_txn;
    di_write_mode = 1'b0;
    di_read_mode  = 1'b0;
    di_write      = 1'b0;
    di_read       = 1'b0;
    di_read_req   = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr_put(input logic [15:0] d);
    int n = 0;
    while (!di_write_rdy && n < 8) begin
      tick();
      n++;
    end
    if (!di_write_rdy) chk("write_rdy_timeout", di_write_rdy, 1);
    di_write     = 1'b1;
    di_reg_datai = d;
    tick();
    di_write     = 1'b0;
  endtask

  task automatic rd_open(input logic [31:0] a, input logic [31:0] len);
    start_txn(1'b0, a, len);
    di_read_req = 1'b1;
    tick();
    di_read_req = 1'b0;
  endtask

  task automatic rd_take(input string name, input logic [15:0] exp);
    int n = 0;
    while (!di_read_rdy && n < 8) begin
      tick();
      n++;
    end
    chk({name, "_rdy"}, di_read_rdy, 1);
    chk(name, di_reg_datao, exp);
    di_read = 1'b1;
    tick();
    di_read = 1'b0;
  endtask

  initial begin
    int base, nok;
    logic [15:0] w0, w1;

    resetb        = 1'b0;
    di_term_addr  = TERM;
    di_reg_addr   = '0;
    di_len        = '0;
    di_write_mode = 1'b0;
    di_read_mode  = 1'b0;
    di_write      = 1'b0;
    di_reg_datai  = '0;
    di_read_req   = 1'b0;
    di_read       = 1'b0;

    tbl[0] = '{32'h0000_0000, 32'h0000_0000, 32'd2,   1,   16'd0};
    tbl[1] = '{32'h0000_01F4, 32'h0000_01F4, 32'd516, 258, 16'd0};
    tbl[2] = '{32'h0000_07FC, 32'h0000_07FC, 32'd8,   4,   16'd0};
    tbl[3] = '{32'h0000_0104, 32'h0000_0104, 32'd2,   1,   16'd0};
    tbl[4] = '{32'h0000_0065, 32'h0000_0064, 32'd4,   2,   16'd1};
    tbl[5] = '{32'h0000_0100, 32'h0000_0100, 32'd4,   3,   16'd2};
    tbl[6] = '{32'h0000_3020, 32'h0000_0020, 32'd6,   3,   16'd0};

    tick();
    tick();
    chk("rst_read_rdy",  di_read_rdy, 0);
    chk("rst_write_rdy", di_write_rdy, 0);
    chk("rst_status",    di_transfer_status, 0);
    chk("rst_datao",     di_reg_datao, 0);
    resetb = 1'b1;
    tick();
    chk("di_en_own", di_en, 1);

    // Table: write a block, check status, read it back from the alias address
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < tbl[k].nw; i++) tdat[i] = 16'($urandom);
      start_txn(1'b1, tbl[k].wa, tbl[k].len);
      for (int i = 0; i < tbl[k].nw; i++) wr_put(tdat[i]);
      chk($sformatf("v%0d_wstatus", k), di_transfer_status, tbl[k].st);
      close_txn();
      nok  = (tbl[k].nw < int'(tbl[k].len / 2)) ? tbl[k].nw : int'(tbl[k].len / 2);
      base = int'(tbl[k].wa[10:1]);
      for (int i = 0; i < nok; i++) model[(base + i) % 1024] = tdat[i];
      if (k == 2) for (int i = 0; i < 4; i++) wrap_dat[i] = tdat[i];
      base = int'(tbl[k].ra[10:1]);
      rd_open(tbl[k].ra, 32'(nok * 2));
      for (int i = 0; i < nok; i++)
        rd_take($sformatf("v%0d_rd%0d", k, i), model[(base + i) % 1024]);
      chk($sformatf("v%0d_rstatus", k), di_transfer_status, 0);
      close_txn();
    end

    // Wrap: second half of the 0x7FC block sits at the bottom of the buffer
    rd_open(32'h0000_0000, 32'd4);
    rd_take("wrap_w2", wrap_dat[2]);
    rd_take("wrap_w3", wrap_dat[3]);
    close_txn();

    // The dropped third write at 0x100 must not have touched byte 0x104
    rd_open(32'h0000_0104, 32'd2);
    rd_take("drop_intact", model[130]);
    close_txn();

    // Read timing: ready two cycles after request and two cycles after consume
    w0 = 16'hA55A;
    w1 = 16'h1234;
    start_txn(1'b1, 32'h0000_02A0, 32'd4);
    wr_put(w0);
    wr_put(w1);
    close_txn();
    start_txn(1'b0, 32'h0000_02A0, 32'd4);
    di_read_req = 1'b1;
    chk("t_rdy_N", di_read_rdy, 0);
    tick();
    di_read_req = 1'b0;
    chk("t_rdy_N1", di_read_rdy, 0);
    tick();
    chk("t_rdy_N2", di_read_rdy, 1);
    chk("t_data0", di_reg_datao, w0);
    di_read = 1'b1;
    tick();
    di_read = 1'b0;
    chk("t_rdy_M1", di_read_rdy, 0);
    chk("t_datao_M1", di_reg_datao, 0);
    tick();
    chk("t_rdy_M2", di_read_rdy, 1);
    chk("t_data1", di_reg_datao, w1);
    chk("t_status_ok", di_transfer_status, 0);
    di_read = 1'b1;
    tick();
    di_read = 1'b0;
    tick();
    // Length is exhausted: a further consume is dropped and flagged
    di_read = 1'b1;
    tick();
    di_read = 1'b0;
    chk("rd_overrun_status", di_transfer_status, 2);
    close_txn();

    // Foreign terminal: strobes ignored, handshakes stay low, memory untouched
    di_term_addr = TERM + 16'd1;
    start_txn(1'b1, 32'h0000_02A0, 32'd4);
    chk("foreign_en", di_en, 0);
    chk("foreign_wrdy", di_write_rdy, 0);
    di_write = 1'b1;
    di_reg_datai = 16'hDEAD;
    tick();
    di_reg_datai = 16'hBEEF;
    tick();
    di_write = 1'b0;
    close_txn();
    di_term_addr = TERM;
    rd_open(32'h0000_02A0, 32'd4);
    rd_take("foreign_w0", w0);
    rd_take("foreign_w1", w1);
    close_txn();

    // Reset while a word is presented, then re-read the same address
    rd_open(32'h0000_02A1, 32'd4);
    tick();
    chk("pre_rst_rdy", di_read_rdy, 1);
    chk("pre_rst_status", di_transfer_status, 1);
    chk("pre_rst_data", di_reg_datao, w0);
    resetb = 1'b0;
    #1;
    chk("async_rst_rdy", di_read_rdy, 0);
    chk("async_rst_datao", di_reg_datao, 0);
    chk("async_rst_status", di_transfer_status, 0);
    chk("async_rst_wrdy", di_write_rdy, 0);
    di_read_mode = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
    tick();
    rd_open(32'h0000_02A0, 32'd4);
    rd_take("post_rst_w0", w0);
    rd_take("post_rst_w1", w1);
    chk("post_rst_status", di_transfer_status, 0);
    close_txn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/di_scratch_term.md
DI_SCRATCH_TERM -- requirements
Module: di_scratch_term

Interface
REQ-001 SHALL have parameter TERM_ADDR, default 16'h0040; the DI terminal address this block answers.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10; log2 of buffer depth in 16-bit words (1024 words, 2 KiB).
REQ-003 SHALL have port ifclk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port resetb  input  1  asynchronous active-low reset.
REQ-005 SHALL have port di_term_addr  input  16  terminal of the current transaction.
REQ-006 SHALL have port di_reg_addr  input  32  byte start address, valid while di_read_mode/di_write_mode is high.
REQ-007 SHALL have port di_len  input  32  transfer length in bytes; even, nonzero.
REQ-008 SHALL have ports di_write_mode, di_read_mode  input  1 each  transaction-direction qualifiers.
REQ-009 SHALL have port di_write  input  1  one-cycle word write strobe; di_reg_datai is valid in the same cycle.
REQ-010 SHALL have port di_reg_datai  input  16  write data, little-endian byte order.
REQ-011 SHALL have ports di_read_req, di_read  input  1 each  prefetch request strobe / word consume strobe.
REQ-012 SHALL have port di_reg_datao  output  16  read data, valid while di_read_rdy is high.
REQ-013 SHALL have ports di_read_rdy, di_write_rdy  output  1 each  ready handshakes.
REQ-014 SHALL have port di_transfer_status  output  16  0 = OK, 1 = odd address, 2 = overrun.
REQ-015 SHALL have port di_en  output  1  high when di_term_addr == TERM_ADDR.

Function
REQ-016 SHALL ignore every strobe while di_en is low; di_read_rdy and di_write_rdy SHALL then be 0.
REQ-017 SHALL load word pointer ptr = di_reg_addr[ADDR_WIDTH:1] on the first cycle di_write_mode or di_read_mode rises with di_en high.
REQ-018 SHALL set di_transfer_status to 1 and ignore di_reg_addr[0] when di_reg_addr[0] = 1.
REQ-019 SHALL silently wrap higher di_reg_addr bits and ptr modulo 2^ADDR_WIDTH words.
REQ-020 SHALL hold di_write_rdy high throughout write mode; each di_write writes di_reg_datai to mem[ptr] in that cycle, and ptr advances by 1.
REQ-021 SHALL implement the read FSM with states IDLE, FETCH and VALID.
REQ-022 SHALL move IDLE->FETCH on di_read_req, FETCH->VALID after exactly one cycle of RAM latency, VALID->FETCH on di_read, and any state->IDLE when di_read_mode falls.
REQ-023 SHALL drive di_read_rdy = (state == VALID), and SHALL advance ptr on each di_read.
REQ-024 SHALL make the first di_read_rdy appear exactly 2 cycles after di_read_req; after a di_read, the next word SHALL be ready 2 cycles later.
REQ-025 SHALL count transferred bytes against di_len; strobes beyond di_len SHALL be dropped, and di_transfer_status SHALL become 2.
REQ-026 SHALL give write priority if di_write_mode and di_read_mode are both high: writes are serviced, the read FSM stays IDLE.
REQ-027 SHALL treat di_read in a non-VALID state as a no-op.
REQ-028 SHALL clear di_transfer_status at the start of each transaction.

Reset
REQ-029 SHALL, with resetb low, clear ptr and the byte count, force FSM=IDLE, and drive di_reg_datao=0, di_read_rdy=0, di_write_rdy=0, di_transfer_status=0 asynchronously.
REQ-030 SHALL abort any transaction in progress on reset; memory contents SHALL NOT be cleared.
REQ-031 SHALL release reset synchronously to ifclk, with outputs valid from the first edge after release.

Structure
REQ-032 SHALL place the status codes and FSM state encodings in the shared di_pkg package.
REQ-033 SHALL contain one sub-module, scratch_ram: a single-port synchronous RAM with 1-cycle read latency.

Verification
REQ-034 Reset: hold resetb low while a read is in VALID -> all outputs 0 within the same cycle; after release, a read of the same address returns its prior data.
REQ-035 Write/read 516 random bytes at byte address 0x1F4 -> readback is identical; di_transfer_status = 0.
REQ-036 Wrap: write 8 bytes at byte address 0x7FC -> words land at mem[0x3FE], mem[0x3FF], mem[0x000], mem[0x001].
REQ-037 Read timing: di_read_req at cycle N -> di_read_rdy at N+2; di_read at M -> next di_read_rdy at M+2.
REQ-038 Errors: start at address 0x65 -> status 1; with di_len = 4, issue 3 di_write strobes -> third dropped, status 2.
REQ-039 Foreign terminal: di_term_addr = TERM_ADDR+1 with strobes -> di_en = 0 and memory unchanged.
